// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl
// Purpose  : Game sequencer: mode menu, FIGHt banner, timed play, result.
// Revision : 1.0
// ============================================================================
module game_flow_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int FIGHT_SECS    = 2,
    parameter int MAX_SECS      = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_select,
    input  logic       btn_start,
    input  logic       p1_dead,
    input  logic       p2_dead,
    input  logic       debug_sw,
    output logic [2:0] hex_state,
    output logic [6:0] game_duration,
    output logic       game_active,
    output logic       mode_2p
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = (FIGHT_SECS > 1) ? $clog2(FIGHT_SECS + 1) : 1;

    localparam logic [2:0] HEX_FIGHT = 3'd2;
    localparam logic [2:0] HEX_P1WIN = 3'd3;
    localparam logic [2:0] HEX_P2WIN = 3'd4;
    localparam logic [2:0] HEX_EQ    = 3'd5;
    localparam logic [2:0] HEX_DEBUG = 3'd6;

    typedef enum logic [1:0] {
        S_MENU   = 2'd0,
        S_FIGHT  = 2'd1,
        S_PLAY   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] prescaler, prescaler_nx;
    logic [SW-1:0] sec_cnt, sec_cnt_nx;
    logic [2:0]    result, result_nx;
    logic [2:0]    hex_nx;
    logic [6:0]    duration_nx;
    logic          mode_nx;
    logic          sec_tick;

    assign sec_tick = ((state == S_FIGHT) || (state == S_PLAY)) &&
                      (prescaler == PW'(TICKS_PER_SEC - 1));

    always_comb begin
        state_nx    = state;
        mode_nx     = mode_2p;
        duration_nx = game_duration;
        sec_cnt_nx  = sec_cnt;
        result_nx   = result;
        case (state)
            S_MENU: begin
                // Toggle is applied before start so the new mode is latched
                if (btn_select) mode_nx = ~mode_2p;
                if (btn_start) begin
                    state_nx    = S_FIGHT;
                    duration_nx = 7'd0;
                    sec_cnt_nx  = '0;
                end
            end
            S_FIGHT: begin
                if (sec_tick) begin
                    sec_cnt_nx = sec_cnt + 1'b1;
                    if (sec_cnt == SW'(FIGHT_SECS - 1)) state_nx = S_PLAY;
                end
            end
            S_PLAY: begin
                if (sec_tick && (game_duration < 7'(MAX_SECS)))
                    duration_nx = game_duration + 7'd1;
                // Death outranks timeout within the same cycle
                if (p2_dead && !p1_dead) begin
                    state_nx  = S_RESULT;
                    result_nx = HEX_P1WIN;
                end else if (p1_dead && !p2_dead) begin
                    state_nx  = S_RESULT;
                    result_nx = HEX_P2WIN;
                end else if (p1_dead && p2_dead) begin
                    state_nx  = S_RESULT;
                    result_nx = HEX_EQ;
                end else if (sec_tick && (game_duration >= 7'(MAX_SECS - 1))) begin
                    state_nx  = S_RESULT;
                    result_nx = HEX_EQ;
                end
            end
            S_RESULT: begin
                if (btn_start) state_nx = S_MENU;
            end
            default: state_nx = S_MENU;
        endcase
    end

    always_comb begin
        prescaler_nx = '0;
        if ((state_nx == state) && ((state == S_FIGHT) || (state == S_PLAY)))
            prescaler_nx = sec_tick ? '0 : prescaler + 1'b1;
    end

    always_comb begin
        hex_nx = 3'd0;
        if (debug_sw) begin
            hex_nx = HEX_DEBUG;
        end else begin
            case (state_nx)
                S_MENU:   hex_nx = {2'b00, mode_nx};
                S_FIGHT:  hex_nx = HEX_FIGHT;
                S_PLAY:   hex_nx = HEX_DEBUG;
                S_RESULT: hex_nx = result_nx;
                default:  hex_nx = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_MENU;
            mode_2p       <= 1'b0;
            hex_state     <= 3'd0;
            game_duration <= 7'd0;
            game_active   <= 1'b0;
            prescaler     <= '0;
            sec_cnt       <= '0;
            result        <= HEX_EQ;
        end else begin
            state         <= state_nx;
            mode_2p       <= mode_nx;
            hex_state     <= hex_nx;
            game_duration <= duration_nx;
            game_active   <= (state_nx == S_PLAY);
            prescaler     <= prescaler_nx;
            sec_cnt       <= sec_cnt_nx;
            result        <= result_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_ctrl
// Purpose  : Directed plus random stimulus against a cycle-count game model.
// Revision : 1.0
// ============================================================================
module tb_game_flow_ctrl;

    localparam int TPS = 4;
    localparam int FS  = 2;
    localparam int MX  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_select = 1'b0;
    logic       btn_start = 1'b0;
    logic       p1_dead = 1'b0;
    logic       p2_dead = 1'b0;
    logic       debug_sw = 1'b0;
    logic [2:0] hex_state;
    logic [6:0] game_duration;
    logic       game_active;
    logic       mode_2p;

    int checks = 0;
    int failures = 0;

    // Reference: phase 0=menu 1=fight 2=play 3=result; cyc = cycles spent in phase
    int m_phase, m_mode, m_cyc, m_dur, m_res, m_hex, m_active;

    game_flow_ctrl #(
        .TICKS_PER_SEC(TPS),
        .FIGHT_SECS   (FS),
        .MAX_SECS     (MX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_select   (btn_select),
        .btn_start    (btn_start),
        .p1_dead      (p1_dead),
        .p2_dead      (p2_dead),
        .debug_sw     (debug_sw),
        .hex_state    (hex_state),
        .game_duration(game_duration),
        .game_active  (game_active),
        .mode_2p      (mode_2p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit st, input bit d1, input bit d2,
                              input bit dbg, input bit r);
        if (r) begin
            m_phase = 0; m_mode = 0; m_cyc = 0; m_dur = 0; m_res = 5;
            m_hex = 0; m_active = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (s) m_mode = 1 - m_mode;
                if (st) begin m_phase = 1; m_cyc = 0; m_dur = 0; end
            end
            1: begin
                m_cyc++;
                if (m_cyc == FS * TPS) begin m_phase = 2; m_cyc = 0; end
            end
            2: begin
                m_cyc++;
                m_dur = (m_cyc / TPS > MX) ? MX : m_cyc / TPS;
                if (d1 || d2) begin
                    m_phase = 3;
                    m_res = (d1 && d2) ? 5 : (d2 ? 3 : 4);
                end else if (m_cyc == MX * TPS) begin
                    m_phase = 3; m_res = 5;
                end
            end
            default: if (st) m_phase = 0;
        endcase
        m_active = (m_phase == 2);
        if (dbg)              m_hex = 6;
        else if (m_phase == 0) m_hex = m_mode;
        else if (m_phase == 1) m_hex = 2;
        else if (m_phase == 2) m_hex = 6;
        else                   m_hex = m_res;
    endtask

    task automatic step(input string tag, input bit s, input bit st, input bit d1,
                        input bit d2, input bit dbg, input bit r);
        btn_select = s; btn_start = st; p1_dead = d1; p2_dead = d2;
        debug_sw = dbg; rst = r;
        @(posedge clk);
        model_step(s, st, d1, d2, dbg, r);
        #1;
        chk({tag, "_hex"}, int'(hex_state), m_hex);
        chk({tag, "_dur"}, int'(game_duration), m_dur);
        chk({tag, "_act"}, int'(game_active), m_active);
        chk({tag, "_mode"}, int'(mode_2p), m_mode);
    endtask

    task automatic idle(input string tag, input int n, input bit dbg);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, dbg, 0);
    endtask

    initial begin
        // 1: reset and menu toggling
        step("rst", 0, 0, 0, 0, 0, 1);
        step("rst", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("sel", 1, 0, 0, 0, 0, 0);
        chk("tp1_mode", int'(mode_2p), 1);
        chk("tp1_hex", int'(hex_state), 1);
        step("selstart", 1, 1, 0, 0, 0, 0);
        chk("tp1_latch", int'(mode_2p), 0);
        chk("tp1_fight", int'(hex_state), 2);
        // 2: banner lasts 8 cycles, then play
        idle("fight", 7, 0);
        chk("tp2_banner", int'(hex_state), 2);
        step("play", 0, 0, 0, 0, 0, 0);
        chk("tp2_play", int'(hex_state), 6);
        chk("tp2_active", int'(game_active), 1);
        idle("play", 12, 0);
        chk("tp2_dur3", int'(game_duration), 3);
        // 4a: simultaneous death -> Eq
        step("both", 0, 0, 1, 1, 0, 0);
        chk("tp4_eq", int'(hex_state), 5);
        // 3: p2 dies at duration 2, result frozen
        step("tomenu", 0, 1, 0, 0, 0, 0);
        step("start", 0, 1, 0, 0, 0, 0);
        idle("fight", 8, 0);
        idle("play", 8, 0);
        step("p2dead", 0, 0, 0, 1, 0, 0);
        chk("tp3_p1win", int'(hex_state), 3);
        chk("tp3_inact", int'(game_active), 0);
        idle("res", 10, 0);
        step("ressel", 1, 0, 0, 0, 0, 0);
        idle("res", 8, 0);
        step("ressel", 1, 0, 0, 0, 0, 0);
        chk("tp3_frozen", int'(game_duration), 2);
        // 4b: timeout draw
        step("tomenu", 0, 1, 0, 0, 0, 0);
        step("start", 0, 1, 0, 0, 0, 0);
        idle("fight", 8, 0);
        idle("play", 20, 0);
        chk("tp4_tdur", int'(game_duration), 5);
        chk("tp4_thex", int'(hex_state), 5);
        // 5: death on the timeout tick wins
        step("tomenu", 0, 1, 0, 0, 0, 0);
        step("start", 0, 1, 0, 0, 0, 0);
        idle("fight", 8, 0);
        idle("play", 19, 0);
        step("p1last", 0, 0, 1, 0, 0, 0);
        chk("tp5_p2win", int'(hex_state), 4);
        chk("tp5_dur", int'(game_duration), 5);
        step("tomenu", 0, 1, 0, 0, 0, 0);
        chk("tp5_menu", int'(hex_state), int'(mode_2p));
        chk("tp5_keep", int'(game_duration), 5);
        // 6: debug override and mid-play reset
        step("dbgmenu", 0, 0, 0, 0, 1, 0);
        chk("tp6_dbg", int'(hex_state), 6);
        step("dbgstart", 0, 1, 0, 0, 1, 0);
        idle("dbgfight", 8, 1);
        idle("dbgplay", 3, 1);
        step("dbgdead", 0, 0, 0, 1, 1, 0);
        chk("tp6_dbgres", int'(hex_state), 6);
        step("undbg", 0, 0, 0, 0, 0, 0);
        chk("tp6_res", int'(hex_state), 3);
        step("tomenu", 0, 1, 0, 0, 0, 0);
        step("start", 0, 1, 0, 0, 0, 0);
        idle("fight", 8, 0);
        idle("play", 6, 0);
        step("midrst", 0, 0, 0, 0, 0, 1);
        chk("tp6_rhex", int'(hex_state), 0);
        chk("tp6_rdur", int'(game_duration), 0);
        chk("tp6_ract", int'(game_active), 0);
        step("postrst", 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom % 8) == 0,
                 ($urandom % 6) == 0,
                 ($urandom % 30) == 0,
                 ($urandom % 30) == 0,
                 ($urandom % 16) == 0,
                 ($urandom % 400) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer that drives the 7-segment text handler.
- Generates hex_state (3-bit text code) and game_duration (seconds, 0..99).
- Walks the game through four phases: mode menu, FIGHt banner, timed play, result display.
- Sits between the debounced buttons/switches plus the player-logic death flags and the hex display path.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per second (bench uses 4).
- FIGHT_SECS, 2, seconds the FIGHt banner is shown before play starts; must be ≥1.
- MAX_SECS, 99, play time limit in seconds; 1..99; reaching it forces a draw.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_select  in  1  single-cycle pulse; toggles 1P/2P in MENU
- btn_start  in  1  single-cycle pulse; MENU→FIGHT, RESULT→MENU
- p1_dead  in  1  level; player 1 eliminated
- p2_dead  in  1  level; player 2 eliminated
- debug_sw  in  1  level; forces debug display code
- hex_state  out  3  text code: 0=1P, 1=2P, 2=FIGHt, 3=P1 win, 4=P2 win, 5=Eq, 6=debug
- game_duration  out  7  elapsed play seconds, binary, ≤MAX_SECS
- game_active  out  1  high only in PLAY
- mode_2p  out  1  selected mode, 0=1P, 1=2P

Behaviour:
- All outputs registered. Reset values:
  - state=MENU, mode_2p=0, hex_state=0, game_duration=0, game_active=0
  - prescaler=0, sec_cnt=0, result register=Eq
- rst mid-operation returns everything to reset values on the next edge, from any state.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 and runs only in FIGHT and PLAY.
  - Cleared on every state entry.
  - sec_tick is asserted in the cycle the prescaler equals TICKS_PER_SEC-1; the prescaler wraps to 0 in that cycle.
- MENU:
  - btn_select toggles mode_2p.
  - btn_start moves to FIGHT and clears game_duration and sec_cnt.
  - If btn_select and btn_start arrive together, the toggle is applied first; the new mode is latched.
  - mode_2p is frozen outside MENU.
- FIGHT:
  - Each sec_tick increments sec_cnt.
  - When a sec_tick would make sec_cnt reach FIGHT_SECS, move to PLAY.
  - Banner duration is exactly FIGHT_SECS*TICKS_PER_SEC cycles.
  - Buttons and death flags are ignored.
- PLAY:
  - game_active=1.
  - sec_tick increments game_duration, saturating at MAX_SECS.
  - p1_dead/p2_dead are sampled every cycle; evaluation order within a cycle:
    1. p2_dead & !p1_dead → RESULT, P1 win (3)
    2. p1_dead & !p2_dead → RESULT, P2 win (4)
    3. both → RESULT, Eq (5)
    4. otherwise, a sec_tick that takes game_duration to MAX_SECS → RESULT, Eq
  - Death takes priority over timeout in the same cycle.
  - Buttons are ignored.
- RESULT:
  - game_duration is frozen.
  - btn_start → MENU; game_duration stays frozen until the next MENU→FIGHT transition.
  - btn_select is ignored.
- hex_state mapping, updated on the same edge as the state register:
  - MENU → mode_2p (0/1); the MENU value reflects the post-toggle mode.
  - FIGHT → 2
  - PLAY → 6
  - RESULT → latched result code
- debug_sw=1 overrides hex_state to 6 in every state from the next edge; the state machine is unaffected.
- game_active deasserts on the same edge that enters RESULT.
- No illegal states are reachable; an unused encoding returns to MENU on the next edge.

Test Plan (TICKS_PER_SEC=4, FIGHT_SECS=2, MAX_SECS=5):
1. Reset, then btn_select ×3 → mode_2p=1, hex_state=1; btn_select+btn_start same cycle → mode_2p=0, hex_state=2 next edge.
2. btn_start in MENU → hex_state=2 for exactly 8 cycles, then 6 with game_active=1 and game_duration=0; after 12 more cycles, game_duration=3.
3. In PLAY at game_duration=2, assert p2_dead → next edge hex_state=3, game_active=0; game_duration stays 2 through 20 cycles and two btn_select pulses.
4. In PLAY assert p1_dead and p2_dead together → hex_state=5; separately, no deaths → after 20 PLAY cycles game_duration=5, hex_state=5.
5. p1_dead asserted in the same cycle as the sec_tick reaching 5 → hex_state=4 (death beats timeout); btn_start → hex_state=mode_2p, game_duration still 5 until the next start.
6. debug_sw=1 in MENU/FIGHT/RESULT → hex_state=6 while the state still advances; rst asserted mid-PLAY → all outputs at reset values after one edge.
